// File: rtl/scu_clk_pkg.sv
// Shared types and defaults for the SCU clock divider bank.
// Holds the channel state enum, default widths and the divisor saturation helper.
package scu_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } chan_state_t;

  localparam int DIVW_DEF    = 8;
  localparam int DIV_RST_DEF = 1;

  // A divisor of 0 would never reach a half boundary, so it runs as 1 (clk/2).
  function automatic int unsigned div_sat(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/scu_clk_div_bank_if.sv
// Control/status bundle for scu_clk_div_bank: per-channel run, config handshake and clocks.
// master drives requests, slave (the bank) returns ready, clocks and busy.
interface scu_clk_div_bank_if #(
  parameter int NCH  = 6,
  parameter int DIVW = scu_clk_pkg::DIVW_DEF
);
  logic [NCH-1:0]      en;
  logic [NCH-1:0]      cfg_valid;
  logic [NCH-1:0]      cfg_ready;
  logic [NCH*DIVW-1:0] cfg_div;
  logic [NCH-1:0]      cfg_inv;
  logic [NCH-1:0]      clk_out;
  logic [NCH-1:0]      busy;

  modport master (
    output en, cfg_valid, cfg_div, cfg_inv,
    input  cfg_ready, clk_out, busy
  );

  modport slave (
    input  en, cfg_valid, cfg_div, cfg_inv,
    output cfg_ready, clk_out, busy
  );
endinterface

// File: rtl/scu_clk_div_chan.sv
// One divider channel: IDLE/RUN/STOP FSM, half-period counter, pending config, output flop.
// clk_out lags the phase register by one cycle; cfg_ready is low while any config field is pending. SCU_CLK_DIV_INV_EN adds inversion.
module scu_clk_div_chan
  import scu_clk_pkg::*;
#(
  parameter int DIVW    = DIVW_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cfg_valid,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            cfg_inv,
  output logic            cfg_ready,
  output logic            clk_out,
  output logic            busy
);

  chan_state_t     state, state_nxt;
  logic            phase;
  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_active;
  logic [DIVW-1:0] pend_div;
  logic [DIVW-1:0] hm1;
  logic            pend_div_vld;
  logic            inv_active;
  logic            pend_inv_vld;
  logic            running;
  logic            half_bnd;
  logic            going_idle;
  logic            period_bnd;
  logic            accept;

  assign running    = (state != ST_IDLE);
  assign hm1        = DIVW'(div_sat(32'(div_active)) - 32'd1);
  assign half_bnd   = running && (cnt == hm1);
  assign going_idle = (state == ST_STOP) && !en && half_bnd && !phase;
  assign period_bnd = half_bnd && !phase && !going_idle;
  assign accept     = cfg_valid && cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (!en) state_nxt = ST_STOP;
      ST_STOP: begin
        if (en)              state_nxt = ST_RUN;
        else if (going_idle) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = !pend_div_vld && !pend_inv_vld;
    busy      = running || !cfg_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= 1'b0;
      cnt          <= '0;
      div_active   <= DIVW'(DIV_RST);
      pend_div     <= '0;
      pend_div_vld <= 1'b0;
      clk_out      <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        phase <= en;
        cnt   <= '0;
      end else if (half_bnd) begin
        cnt <= '0;
        if (!going_idle) phase <= !phase;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A divisor accepted on a boundary edge only sees later boundaries.
      if (accept) begin
        pend_div     <= cfg_div;
        pend_div_vld <= 1'b1;
      end else if (pend_div_vld && (state == ST_IDLE || period_bnd)) begin
        div_active   <= pend_div;
        pend_div_vld <= 1'b0;
      end

      clk_out <= phase ^ inv_active;
    end
  end

`ifdef SCU_CLK_DIV_INV_EN
  logic pend_inv;

  // An unchanged inversion request is not held pending, so it never stalls the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_active   <= 1'b0;
      pend_inv     <= 1'b0;
      pend_inv_vld <= 1'b0;
    end else if (accept) begin
      pend_inv     <= cfg_inv;
      pend_inv_vld <= (cfg_inv != inv_active);
    end else if (pend_inv_vld && state == ST_IDLE) begin
      inv_active   <= pend_inv;
      pend_inv_vld <= 1'b0;
    end
  end
`else
  logic unused_cfg_inv;
  assign unused_cfg_inv = cfg_inv;
  assign inv_active     = 1'b0;
  assign pend_inv_vld   = 1'b0;
`endif

endmodule

// File: rtl/scu_clk_div_bank.sv
// NCH independent glitch-free clock dividers; one registered clock per channel, one-cycle start latency.
// Per-channel valid/ready divisor reload; optional inversion under SCU_CLK_DIV_INV_EN.
module scu_clk_div_bank
  import scu_clk_pkg::*;
#(
  parameter int NCH     = 6,
  parameter int DIVW    = DIVW_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input logic                clk,
  input logic                rst,
  scu_clk_div_bank_if.slave  bus
);

  logic [NCH-1:0] rdy_w;
  logic [NCH-1:0] clk_w;
  logic [NCH-1:0] busy_w;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    scu_clk_div_chan #(
      .DIVW    (DIVW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en[i]),
      .cfg_valid (bus.cfg_valid[i]),
      .cfg_div   (bus.cfg_div[i*DIVW +: DIVW]),
      .cfg_inv   (bus.cfg_inv[i]),
      .cfg_ready (rdy_w[i]),
      .clk_out   (clk_w[i]),
      .busy      (busy_w[i])
    );
  end

  assign bus.cfg_ready = rdy_w;
  assign bus.clk_out   = clk_w;
  assign bus.busy      = busy_w;

endmodule

// File: tb/tb_scu_clk_div_bank.sv
// Directed bench for scu_clk_div_bank: period table per channel plus start, reload, stop and reset sequences.
module tb_scu_clk_div_bank;

  localparam int NCH  = 6;
  localparam int DIVW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scu_clk_div_bank_if #(.NCH(NCH), .DIVW(DIVW)) bus ();

  scu_clk_div_bank #(.NCH(NCH), .DIVW(DIVW), .DIV_RST(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         ch;
    logic [7:0] div;
    int         exp_h;
    int         exp_l;
    int         exp_rdy_low;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int ch, input logic [7:0] d, input logic inv);
    bus.cfg_div[ch*DIVW +: DIVW] = d;
    bus.cfg_inv[ch]   = inv;
    bus.cfg_valid[ch] = 1'b1;
    tick();
    bus.cfg_valid[ch] = 1'b0;
  endtask

  task automatic wait_out(input int ch, input logic v, input string nm);
    int g = 0;
    while (bus.clk_out[ch] !== v && g < 300) begin tick(); g++; end
    if (g >= 300) chk(nm, 64'(bus.clk_out[ch]), 64'(v));
  endtask

  task automatic count_lvl(input int ch, input logic v, output int n);
    n = 0;
    while (bus.clk_out[ch] === v && n < 600) begin n++; tick(); end
  endtask

  task automatic wait_idle(input int ch, input string nm);
    int g = 0;
    while (bus.busy[ch] !== 1'b0 && g < 300) begin tick(); g++; end
    chk(nm, 64'(bus.busy[ch]), 64'd0);
  endtask

  initial begin
    int h, l, n;
    logic rdy_prev, rdy_last;

    vecs[0] = '{1, 8'd3,  3,  3,  1};
    vecs[1] = '{5, 8'd0,  1,  1,  1};
    vecs[2] = '{2, 8'd2,  2,  2,  1};
    vecs[3] = '{4, 8'd7,  7,  7,  1};
    vecs[4] = '{0, 8'd1,  1,  1,  1};
    vecs[5] = '{3, 8'd12, 12, 12, 1};

    bus.en = '0; bus.cfg_valid = '0; bus.cfg_div = '0; bus.cfg_inv = '0;
    tick(); tick();
    chk("rst_clk_out", 64'(bus.clk_out), 64'h00);
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'h3f);
    chk("rst_busy", 64'(bus.busy), 64'h00);
    rst = 1'b0;
    tick();

    // Channel 0 at the reset divisor: toggles every cycle from the cycle after en.
    bus.en[0] = 1'b1;
    tick();
    chk("ch0_start_lvl", 64'(bus.clk_out), 64'h00);
    chk("ch0_start_busy", 64'(bus.busy), 64'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ch0_toggle", 64'(bus.clk_out), (k % 2 == 0) ? 64'h01 : 64'h00);
    end
    bus.en[0] = 1'b0;
    wait_idle(0, "ch0_idle");

    // Table: load divisor in IDLE, run, measure the first full period, stop.
    for (int v = 0; v < 6; v++) begin
      send_cfg(vecs[v].ch, vecs[v].div, 1'b0);
      n = 0;
      while (bus.cfg_ready[vecs[v].ch] === 1'b0 && n < 20) begin n++; tick(); end
      chk($sformatf("tbl%0d_rdy_low", v), 64'(n), 64'(vecs[v].exp_rdy_low));
      bus.en[vecs[v].ch] = 1'b1;
      wait_out(vecs[v].ch, 1'b1, $sformatf("tbl%0d_rise_to", v));
      count_lvl(vecs[v].ch, 1'b1, h);
      count_lvl(vecs[v].ch, 1'b0, l);
      chk($sformatf("tbl%0d_high", v), 64'(h), 64'(vecs[v].exp_h));
      chk($sformatf("tbl%0d_low", v), 64'(l), 64'(vecs[v].exp_l));
      bus.en[vecs[v].ch] = 1'b0;
      wait_idle(vecs[v].ch, $sformatf("tbl%0d_idle", v));
      chk($sformatf("tbl%0d_idle_lvl", v), 64'(bus.clk_out[vecs[v].ch]), 64'd0);
    end

    // Channel 2: reload 4 -> 2 in the middle of a high half.
    send_cfg(2, 8'd4, 1'b0);
    tick();
    bus.en[2] = 1'b1;
    wait_out(2, 1'b1, "ch2_rise_to");
    tick();
    send_cfg(2, 8'd2, 1'b0);
    chk("ch2_rdy_after_accept", 64'(bus.cfg_ready[2]), 64'd0);
    count_lvl(2, 1'b1, h);
    chk("ch2_rest_high", 64'(h), 64'd2);
    l = 0; rdy_prev = 1'bx; rdy_last = 1'bx;
    while (bus.clk_out[2] === 1'b0 && l < 50) begin
      rdy_prev = rdy_last; rdy_last = bus.cfg_ready[2]; l++; tick();
    end
    chk("ch2_old_low", 64'(l), 64'd4);
    chk("ch2_rdy_before_bnd", 64'(rdy_prev), 64'd0);
    chk("ch2_rdy_after_bnd", 64'(rdy_last), 64'd1);
    count_lvl(2, 1'b1, h);
    count_lvl(2, 1'b0, l);
    chk("ch2_new_high", 64'(h), 64'd2);
    chk("ch2_new_low", 64'(l), 64'd2);
    bus.en[2] = 1'b0;
    wait_idle(2, "ch2_idle");

    // Channel 3 at div 5: stop during the high half.
    send_cfg(3, 8'd5, 1'b0);
    tick();
    bus.en[3] = 1'b1;
    wait_out(3, 1'b1, "ch3_rise_to");
    tick();
    bus.en[3] = 1'b0;
    count_lvl(3, 1'b1, h);
    chk("ch3_stop_high", 64'(h), 64'd4);
    l = 0;
    while (bus.clk_out[3] === 1'b0 && bus.busy[3] === 1'b1 && l < 50) begin l++; tick(); end
    chk("ch3_low_before_idle", 64'(l), 64'd4);
    chk("ch3_busy_idle", 64'(bus.busy[3]), 64'd0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.clk_out[3] !== 1'b0) n++;
      tick();
    end
    chk("ch3_no_runt", 64'(n), 64'd0);

    // Channel 3: drop en in the high half, re-assert in the low half.
    bus.en[3] = 1'b1;
    wait_out(3, 1'b1, "ch3b_rise_to");
    tick();
    bus.en[3] = 1'b0;
    count_lvl(3, 1'b1, h);
    tick(); tick();
    bus.en[3] = 1'b1;
    count_lvl(3, 1'b0, l);
    chk("ch3_resume_low", 64'(l + 2), 64'd5);
    count_lvl(3, 1'b1, h);
    chk("ch3_resume_high", 64'(h), 64'd5);
    chk("ch3_resume_busy", 64'(bus.busy[3]), 64'd1);
    bus.en[3] = 1'b0;
    wait_idle(3, "ch3b_idle");

`ifdef SCU_CLK_DIV_INV_EN
    // Channel 4: inversion requested while running only lands once IDLE.
    bus.en[4] = 1'b1;
    wait_out(4, 1'b1, "ch4_rise_to");
    send_cfg(4, 8'd2, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cfg_ready[4] !== 1'b0) n++;
      tick();
    end
    chk("ch4_rdy_held", 64'(n), 64'd0);
    bus.en[4] = 1'b0;
    wait_idle(4, "ch4_idle");
    tick(); tick();
    chk("ch4_idle_high", 64'(bus.clk_out[4]), 64'd1);
    bus.en[4] = 1'b1;
    tick();
    chk("ch4_start_high", 64'(bus.clk_out[4]), 64'd1);
    tick();
    chk("ch4_first_fall", 64'(bus.clk_out[4]), 64'd0);
    bus.en[4] = 1'b0;
    wait_idle(4, "ch4b_idle");
`endif

    // Async reset mid-period with a config pending on channel 5.
    bus.en[0] = 1'b1; bus.en[1] = 1'b1; bus.en[5] = 1'b1;
    tick(); tick(); tick();
    send_cfg(5, 8'd9, 1'b0);
    chk("ch5_pending", 64'(bus.cfg_ready[5]), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_out", 64'(bus.clk_out), 64'h00);
    chk("arst_cfg_ready", 64'(bus.cfg_ready), 64'h3f);
    chk("arst_busy", 64'(bus.busy), 64'h00);
    bus.en = '0;
    tick();
    rst = 1'b0;
    tick();
    bus.en[1] = 1'b1;
    wait_out(1, 1'b1, "ch1_post_rst_to");
    count_lvl(1, 1'b1, h);
    count_lvl(1, 1'b0, l);
    chk("ch1_post_rst_high", 64'(h), 64'd1);
    chk("ch1_post_rst_low", 64'(l), 64'd1);
    bus.en[1] = 1'b0;
    wait_idle(1, "ch1_post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scu_clk_div_bank.md
# scu_clk_div_bank

Parametrised multi-channel clock divider/gater for the SCU. It is the successor to the fixed six-channel inverter bank. Each channel derives a registered, glitch-free divided clock from the single SCU clock. Each channel has a run/stop enable, a divisor reloaded through a valid/ready handshake, and optional output inversion. Outputs feed peripheral clock pins and low-rate functional clocks.

## Interface
- NCH, 6: number of channels
- DIVW, 8: divisor width
- DIV_RST, 1: divisor loaded at reset (half-period in clk cycles)
- clk  in  1  SCU clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  NCH  per-channel run request
- cfg_valid  in  NCH  per-channel config request
- cfg_ready  out  NCH  per-channel config accept; high when no config pending
- cfg_div  in  NCH*DIVW  channel i divisor in bits [i*DIVW +: DIVW]
- cfg_inv  in  NCH  requested inversion per channel
- clk_out  out  NCH  registered divided clocks
- busy  out  NCH  channel not IDLE, or config pending

## Operation
- Half-period H = max(div_active, 1) clk cycles. Output period = 2*H. Divisor 0 is treated as 1, giving clk/2.
- Per-channel state: IDLE, RUN, STOP.
  - IDLE: phase=0, cnt=0.
  - IDLE→RUN when en=1. On that edge phase<=1 and cnt<=0.
  - RUN: cnt increments. At cnt==H-1, phase toggles and cnt<=0. That cycle is a "half boundary". A boundary with phase 0→1 is a "period boundary".
  - RUN→STOP when en=0.
  - STOP: keeps counting. At the half boundary where phase=0 (end of the low half), go to IDLE instead of toggling.
  - en=1 during STOP returns to RUN with no disturbance of phase or cnt.
- clk_out[i] = phase ^ inv_active, driven from a flop. In IDLE, clk_out holds inv_active.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready. cfg_div and cfg_inv are captured into pending registers and cfg_ready drops.
  - Pending divisor: applied at the first period boundary strictly after acceptance, or on the next cycle if the channel is IDLE.
  - Pending inversion: applied only while IDLE.
  - cfg_ready rises on the cycle after all pending fields are applied.
- Simultaneous events:
  - en rise in the same cycle as a config accept in IDLE: the channel starts with the old divisor. The new divisor applies at the next period boundary.
  - A config accept on the same edge as a boundary waits for the following period boundary.
- Arithmetic: cnt is DIVW bits wide, and the compare uses H-1 computed at DIVW width.

## Timing
- Reset values: clk_out=0, cfg_ready=all 1, busy=0, phase=0, cnt=0, state IDLE, div_active=DIV_RST, inv_active=0, pending cleared.
- Start latency: en sampled high at edge t gives clk_out edge at t+1. The first half-period is a full H cycles.
- Stop: clk_out reaches its idle level only after a complete low half. No runt pulse.
- Reset asserted mid-operation: all channels return to reset values immediately (asynchronous). Pending configs are lost.
- Channels are fully independent. No cross-channel skew beyond the flop clk-to-q.

## Configuration
- SCU_CLK_DIV_INV_EN
  - Defined: the per-channel inversion path, the cfg_inv capture and the IDLE-only apply logic are present.
  - Undefined: cfg_inv is ignored and inv_active is tied to 0, so clk_out = phase. The handshake depends on the divisor only.

## Structure
- Package scu_clk_pkg holds:
  - the channel state enum (IDLE/RUN/STOP)
  - default DIVW and DIV_RST localparams
  - a divisor-saturate function (0→1)
- Sub-module scu_clk_div_chan implements one channel: state, counter, pending config and output flop. The top generates NCH instances and slices the buses.

## Test plan
- Reset release, en[0]=1 with DIV_RST=1 → clk_out[0] toggles every cycle (period 2) starting the cycle after en is sampled. Other outputs stay 0.
- cfg_div[1]=3 accepted in IDLE, then en[1]=1 → 3 cycles high, 3 low, repeating. cfg_ready[1] is low for exactly one cycle.
- Channel 2 running at div 4; cfg_div=2 accepted mid-high-half → current period completes at 4/4, next period is 2/2. cfg_ready rises the cycle after that boundary.
- en[3] dropped during the high half at div 5 → high half completes, a full 5-cycle low half follows, then IDLE with busy[3]=0. Re-asserting en during the low half continues without a gap.
- With the macro defined, cfg_inv[4]=1 sent while running → cfg_ready stays low until stop. After IDLE, clk_out[4] idles high and restarts with a falling first edge.
- cfg_div=0 → behaves as div 1. Async rst pulse mid-period → all clk_out go 0 immediately and cfg_ready returns to all 1.
